// File: rtl/unibus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : unibus_pkg
// Description : Shared types and constants for the UNIBUS bus arbiter:
//               arbiter state encoding, grant-select encoding, default
//               SACK timeout and a grant-select to BG decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package unibus_pkg;

    // Default number of cycles a grant may stay unanswered (10 us @ 100 MHz)
    localparam int DEF_SACK_TMO = 1000;

    // Width of the SACK timeout counter
    localparam int c_cnt_w = 16;

    // Arbiter state encoding
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_SACKED  = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    // Grant-select encoding: which request currently owns the grant
    typedef enum logic [2:0] {
        SEL_NONE = 3'd0,
        SEL_HLT  = 3'd1,
        SEL_NPR  = 3'd2,
        SEL_BR7  = 3'd3,
        SEL_BR6  = 3'd4,
        SEL_BR5  = 3'd5,
        SEL_BR4  = 3'd6
    } sel_t;

    // Decode a grant select into the BG7..BG4 vector (bit 3 = BG7)
    function automatic logic [3:0] sel_to_bg(input sel_t sel);
        case (sel)
            SEL_BR7: return 4'b1000;
            SEL_BR6: return 4'b0100;
            SEL_BR5: return 4'b0010;
            SEL_BR4: return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/unibus_sync2.sv
`default_nettype none
// ============================================================================
// Module      : unibus_sync2
// Description : Width-parameterized two-flop synchronizer. Resets to all
//               ones so active-low bus lines start out negated.
// Revision    : 1.0 - initial release
// ============================================================================
module unibus_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // Two-stage capture of the asynchronous inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/unibus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : unibus_arbiter
// Description : UNIBUS bus arbiter. Synchronizes the bus request lines,
//               picks one winner in fixed priority (HLTRQ > NPR > BR7..BR4),
//               and walks the grant through GRANT/SACKED/RELEASE with a
//               SACK timeout. Define UNIBUS_ARB_HLTGR_EN to enable halt
//               request arbitration; without it HLTRQ is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module unibus_arbiter
    import unibus_pkg::*;
#(
    parameter int SACK_TMO = DEF_SACK_TMO
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic [7:4] br_in_l,
    input  logic       npr_in_l,
    input  logic       hltrq_in_l,
    input  logic       sack_in_l,
    input  logic       bbsy_in_l,
    input  logic [2:0] cpu_pri,
    input  logic       cpu_instend,
    input  logic       cpu_cycend,
    output logic [7:4] bg_out_h,
    output logic       npg_out_h,
    output logic       hltgr_out_h,
    output logic       cpu_hold,
    output logic       sack_tmo
);

    localparam logic [c_cnt_w-1:0] c_tmo_load = c_cnt_w'(SACK_TMO);

`ifdef UNIBUS_ARB_HLTGR_EN
    localparam int c_sync_w = 8;
`else
    localparam int c_sync_w = 7;
`endif

    // ------------------------------------------------------------------
    // Input synchronization (all *_in_l lines, active low)
    // ------------------------------------------------------------------
    logic [c_sync_w-1:0] w_sync_in;
    logic [c_sync_w-1:0] w_sync_out;

`ifdef UNIBUS_ARB_HLTGR_EN
    assign w_sync_in = {hltrq_in_l, npr_in_l, sack_in_l, bbsy_in_l, br_in_l};
`else
    // HLTRQ is not arbitrated in this build; the line is deliberately dropped
    logic w_unused_hltrq;
    assign w_unused_hltrq = hltrq_in_l;
    assign w_sync_in      = {npr_in_l, sack_in_l, bbsy_in_l, br_in_l};
`endif

    unibus_sync2 #(
        .WIDTH (c_sync_w)
    ) u_sync (
        .clk   (CLOCK),
        .rst_n (RESET_N),
        .i_d   (w_sync_in),
        .o_q   (w_sync_out)
    );

    // Synchronized lines converted to active-high
    logic [3:0] w_br;       // bit 3 = BR7 ... bit 0 = BR4
    logic       w_bbsy;
    logic       w_sack;
    logic       w_npr;
    logic       w_hlt;

    assign w_br   = ~w_sync_out[3:0];
    assign w_bbsy = ~w_sync_out[4];
    assign w_sack = ~w_sync_out[5];
    assign w_npr  = ~w_sync_out[6];
`ifdef UNIBUS_ARB_HLTGR_EN
    assign w_hlt  = ~w_sync_out[7];
`else
    assign w_hlt  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Eligibility
    // ------------------------------------------------------------------
    logic [3:0] w_br_elig;
    logic       w_npr_elig;
    logic       w_hlt_elig;

    // BR level n may win only above the processor priority at an instruction boundary
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_br_elig
            localparam logic [2:0] c_lvl = 3'(gi + 4);
            assign w_br_elig[gi] = w_br[gi] & cpu_instend & (c_lvl > cpu_pri);
        end
    endgenerate

    assign w_npr_elig = w_npr & cpu_cycend;
    assign w_hlt_elig = w_hlt & cpu_cycend;

    // Fixed-priority winner selection; nothing wins while SACK is still asserted
    sel_t w_win;
    always_comb begin
        w_win = SEL_NONE;
        if (!w_sack) begin
            if (w_hlt_elig)        w_win = SEL_HLT;
            else if (w_npr_elig)   w_win = SEL_NPR;
            else if (w_br_elig[3]) w_win = SEL_BR7;
            else if (w_br_elig[2]) w_win = SEL_BR6;
            else if (w_br_elig[1]) w_win = SEL_BR5;
            else if (w_br_elig[0]) w_win = SEL_BR4;
        end
    end

    // ------------------------------------------------------------------
    // Grant state machine
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_nxt;
    sel_t                 r_sel;
    sel_t                 w_sel_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_cnt_w-1:0]   w_cnt_nxt;
    logic                 r_tmo;
    logic                 w_tmo_nxt;
    logic                 w_req_act;

    // Is the request that owns the current grant still asserted?
    always_comb begin
        w_req_act = 1'b0;
        case (r_sel)
            SEL_HLT: w_req_act = w_hlt;
            SEL_NPR: w_req_act = w_npr;
            SEL_BR7: w_req_act = w_br[3];
            SEL_BR6: w_req_act = w_br[2];
            SEL_BR5: w_req_act = w_br[1];
            SEL_BR4: w_req_act = w_br[0];
            default: w_req_act = 1'b0;
        endcase
    end

    // Next-state, grant-owner, timeout counter and timeout pulse
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_cnt_nxt   = r_cnt;
        w_tmo_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_win != SEL_NONE) begin
                    w_state_nxt = ST_GRANT;
                    w_sel_nxt   = w_win;
                    w_cnt_nxt   = c_tmo_load;
                end
            end
            ST_GRANT: begin
                // SACK takes precedence over both passive release and timeout
                if (w_sack) begin
                    w_state_nxt = ST_SACKED;
                    w_sel_nxt   = SEL_NONE;
                    w_cnt_nxt   = '0;
                end else if (!w_req_act) begin
                    w_state_nxt = ST_IDLE;
                    w_sel_nxt   = SEL_NONE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt <= c_cnt_w'(1)) begin
                    w_state_nxt = ST_IDLE;
                    w_sel_nxt   = SEL_NONE;
                    w_cnt_nxt   = '0;
                    w_tmo_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt - c_cnt_w'(1);
                end
            end
            ST_SACKED: begin
                if (w_bbsy && !w_sack) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!w_bbsy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_sel_nxt   = SEL_NONE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and datapath registers; reset drops any grant immediately
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_sel   <= SEL_NONE;
            r_cnt   <= '0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: a grant line is driven only in GRANT, so at most one is high
    // ------------------------------------------------------------------
    logic w_granting;
    assign w_granting = (r_state == ST_GRANT);

    assign bg_out_h  = w_granting ? sel_to_bg(r_sel) : 4'b0000;
    assign npg_out_h = w_granting && (r_sel == SEL_NPR);
`ifdef UNIBUS_ARB_HLTGR_EN
    assign hltgr_out_h = w_granting && (r_sel == SEL_HLT);
`else
    assign hltgr_out_h = 1'b0;
`endif
    assign cpu_hold  = (r_state != ST_IDLE);
    assign sack_tmo  = r_tmo;

endmodule
`default_nettype wire

// File: tb/tb_unibus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_unibus_arbiter
// Description : Directed self-checking bench for unibus_arbiter (SACK_TMO=20).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_unibus_arbiter;
    import unibus_pkg::*;

    logic       CLOCK = 1'b0;
    logic       RESET_N;
    logic [7:4] br_in_l;
    logic       npr_in_l;
    logic       hltrq_in_l;
    logic       sack_in_l;
    logic       bbsy_in_l;
    logic [2:0] cpu_pri;
    logic       cpu_instend;
    logic       cpu_cycend;
    logic [7:4] bg_out_h;
    logic       npg_out_h;
    logic       hltgr_out_h;
    logic       cpu_hold;
    logic       sack_tmo;

    int n_run  = 0;
    int n_fail = 0;

    unibus_arbiter #(
        .SACK_TMO (20)
    ) dut (
        .CLOCK       (CLOCK),
        .RESET_N     (RESET_N),
        .br_in_l     (br_in_l),
        .npr_in_l    (npr_in_l),
        .hltrq_in_l  (hltrq_in_l),
        .sack_in_l   (sack_in_l),
        .bbsy_in_l   (bbsy_in_l),
        .cpu_pri     (cpu_pri),
        .cpu_instend (cpu_instend),
        .cpu_cycend  (cpu_cycend),
        .bg_out_h    (bg_out_h),
        .npg_out_h   (npg_out_h),
        .hltgr_out_h (hltgr_out_h),
        .cpu_hold    (cpu_hold),
        .sack_tmo    (sack_tmo)
    );

    always #5 CLOCK = ~CLOCK;

    // Advance n rising edges, then settle 1 time unit past the edge
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CLOCK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int len;
    int pulses;
    int bad;

    initial begin
        // ---------------- reset state ----------------
        RESET_N = 1'b0; br_in_l = 4'hF; npr_in_l = 1'b1; hltrq_in_l = 1'b1;
        sack_in_l = 1'b1; bbsy_in_l = 1'b1; cpu_pri = 3'd7;
        cpu_instend = 1'b0; cpu_cycend = 1'b0;
        tick(2);
        chk("rst_bg", 32'(bg_out_h), 32'h0);
        chk("rst_npg", 32'(npg_out_h), 32'h0);
        chk("rst_hltgr", 32'(hltgr_out_h), 32'h0);
        chk("rst_hold", 32'(cpu_hold), 32'h0);
        chk("rst_tmo", 32'(sack_tmo), 32'h0);
        chk("rst_cnt", 32'(dut.r_cnt), 32'h0);

        // ---------------- first grant >= 3 edges after reset release ----------------
        br_in_l = 4'b0111; cpu_pri = 3'd0; cpu_instend = 1'b1;
        tick(2);
        chk("in_rst_bg", 32'(bg_out_h), 32'h0);
        RESET_N = 1'b1;
        tick(2);
        chk("post_rst_bg_e2", 32'(bg_out_h), 32'h0);
        tick(1);
        chk("post_rst_bg_e3", 32'(bg_out_h), 32'h8);
        chk("post_rst_hold", 32'(cpu_hold), 32'h1);
        // passive release: request negates without SACK
        br_in_l = 4'hF;
        tick(2);
        chk("passive_still", 32'(bg_out_h), 32'h8);
        tick(1);
        chk("passive_drop", 32'(bg_out_h), 32'h0);
        chk("passive_hold", 32'(cpu_hold), 32'h0);
        tick(4);

        // ---------------- BR7+BR5 above pri 4, SACK handshake ----------------
        cpu_pri = 3'd4; br_in_l = 4'b0101;
        tick(2);
        chk("br75_e2", 32'(bg_out_h), 32'h0);
        tick(1);
        chk("br75_e3", 32'(bg_out_h), 32'h8);
        sack_in_l = 1'b0;
        tick(2);
        chk("br75_sack_e2", 32'(bg_out_h), 32'h8);
        tick(1);
        chk("br75_sack_drop", 32'(bg_out_h), 32'h0);
        chk("br75_sacked_hold", 32'(cpu_hold), 32'h1);
        bbsy_in_l = 1'b0; sack_in_l = 1'b1; br_in_l = 4'hF;
        tick(3);
        chk("br75_release_st", 32'(dut.r_state), 32'(ST_RELEASE));
        bbsy_in_l = 1'b1;
        tick(3);
        chk("br75_idle_hold", 32'(cpu_hold), 32'h0);
        tick(4);

        // ---------------- BR5 at pri 5: blocked, then granted at pri 4 ----------------
        cpu_pri = 3'd5; br_in_l = 4'b1101;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (bg_out_h != 4'b0000) bad++;
        end
        chk("br5_blocked_cycles", 32'(bad), 32'h0);
        cpu_pri = 3'd4;
        tick(1);
        chk("br5_granted", 32'(bg_out_h), 32'h2);
        br_in_l = 4'hF;
        tick(3);
        chk("br5_released", 32'(bg_out_h), 32'h0);
        tick(4);

        // ---------------- SACK asserted in IDLE blocks grants ----------------
        sack_in_l = 1'b0; cpu_pri = 3'd0; br_in_l = 4'b0111;
        tick(10);
        chk("sack_block", 32'(bg_out_h), 32'h0);
        sack_in_l = 1'b1;
        tick(2);
        chk("sack_unblock_e2", 32'(bg_out_h), 32'h0);
        tick(1);
        chk("sack_unblock_e3", 32'(bg_out_h), 32'h8);
        br_in_l = 4'hF;
        tick(6);

        // ---------------- NPR beats BR7, full handshake ----------------
        cpu_cycend = 1'b1; npr_in_l = 1'b0; br_in_l = 4'b0111;
        tick(3);
        chk("npr_npg", 32'(npg_out_h), 32'h1);
        chk("npr_bg", 32'(bg_out_h), 32'h0);
        chk("npr_hold", 32'(cpu_hold), 32'h1);
        sack_in_l = 1'b0;
        tick(3);
        chk("npr_sack_npg", 32'(npg_out_h), 32'h0);
        chk("npr_sack_hold", 32'(cpu_hold), 32'h1);
        bbsy_in_l = 1'b0; sack_in_l = 1'b1; npr_in_l = 1'b1; br_in_l = 4'hF;
        tick(3);
        chk("npr_rel_hold", 32'(cpu_hold), 32'h1);
        bbsy_in_l = 1'b1;
        tick(2);
        chk("npr_rel_hold_e2", 32'(cpu_hold), 32'h1);
        tick(1);
        chk("npr_done_hold", 32'(cpu_hold), 32'h0);
        tick(4);

        // ---------------- SACK timeout (20 cycles) ----------------
        cpu_instend = 1'b0; npr_in_l = 1'b0;
        tick(3);
        chk("tmo_grant", 32'(npg_out_h), 32'h1);
        len = 1; pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (npg_out_h) len++;
            if (sack_tmo) pulses++;
            if (!npg_out_h && cpu_cycend) begin
                cpu_cycend = 1'b0;
                npr_in_l = 1'b1;
            end
        end
        chk("tmo_grant_len", 32'(len), 32'd20);
        chk("tmo_pulses", 32'(pulses), 32'd1);
        chk("tmo_hold", 32'(cpu_hold), 32'h0);
        chk("tmo_cnt", 32'(dut.r_cnt), 32'h0);
        tick(4);

        // ---------------- reset mid-grant drops NPG asynchronously ----------------
        cpu_cycend = 1'b1; npr_in_l = 1'b0;
        tick(3);
        chk("mid_npg", 32'(npg_out_h), 32'h1);
        #2 RESET_N = 1'b0;
        #1;
        chk("mid_rst_npg", 32'(npg_out_h), 32'h0);
        chk("mid_rst_state", 32'(dut.r_state), 32'(ST_IDLE));
        chk("mid_rst_hold", 32'(cpu_hold), 32'h0);
        npr_in_l = 1'b1;
        tick(1);
        RESET_N = 1'b1;
        tick(4);

        // ---------------- HLTRQ + NPR ----------------
        hltrq_in_l = 1'b0; npr_in_l = 1'b0;
        tick(3);
`ifdef UNIBUS_ARB_HLTGR_EN
        chk("hlt_hltgr", 32'(hltgr_out_h), 32'h1);
        chk("hlt_npg", 32'(npg_out_h), 32'h0);
`else
        chk("hlt_hltgr", 32'(hltgr_out_h), 32'h0);
        chk("hlt_npg", 32'(npg_out_h), 32'h1);
`endif
        hltrq_in_l = 1'b1; npr_in_l = 1'b1;
        tick(3);
        chk("hlt_rel_npg", 32'(npg_out_h), 32'h0);
        chk("hlt_rel_hltgr", 32'(hltgr_out_h), 32'h0);
        chk("hlt_rel_hold", 32'(cpu_hold), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
